// File: rtl/mips_mem_arbiter.sv
// Two-requester arbiter (instruction fetch / load-store) in front of a single-port
// data memory with a fixed read latency; one access in flight at a time.
module mips_mem_arbiter #(
   parameter int ADDR_WIDTH  = 18,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_LATENCY = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic                  dm_byte,
   input  logic [ADDR_WIDTH-1:0] dm_addr,
   input  logic [DATA_WIDTH-1:0] dm_wdata,
   output logic                  dm_gnt,
   output logic                  dm_rvalid,
   output logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic                  mem_byte,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic       SEL_FETCH = 1'b0;
   localparam logic       SEL_DATA  = 1'b1;
   localparam logic [3:0] LAT_M1    = 4'(MEM_LATENCY - 1);

   state_t     state_q, state_d;
   logic       last_winner_q;
   logic       sel_q;
   logic       op_we_q;
   logic [3:0] cnt_q;
   logic       any_req;
   logic       pick_dm;

   // Data wins when alone, or on a tie when fetch won the previous access.
   assign any_req = if_req | dm_req;
   assign pick_dm = dm_req & (~if_req | (last_winner_q == SEL_FETCH));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = ISSUE;
         ISSUE:   state_d = (MEM_LATENCY == 1) ? DONE : WAIT;
         WAIT:    if (cnt_q == 4'd1) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         last_winner_q <= SEL_FETCH;
         sel_q         <= SEL_FETCH;
         op_we_q       <= 1'b0;
         cnt_q         <= 4'd0;
         if_gnt        <= 1'b0;
         if_rvalid     <= 1'b0;
         if_rdata      <= '0;
         dm_gnt        <= 1'b0;
         dm_rvalid     <= 1'b0;
         dm_rdata      <= '0;
         mem_en        <= 1'b0;
         mem_we        <= 1'b0;
         mem_byte      <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
      end else begin
         state_q   <= state_d;
         if_gnt    <= 1'b0;
         dm_gnt    <= 1'b0;
         if_rvalid <= 1'b0;
         dm_rvalid <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  // Strobes are set here so they are flop outputs during ISSUE.
                  sel_q    <= pick_dm ? SEL_DATA : SEL_FETCH;
                  op_we_q  <= pick_dm & dm_we;
                  mem_en   <= 1'b1;
                  mem_we   <= pick_dm & dm_we;
                  mem_byte <= pick_dm & dm_byte;
                  mem_addr <= pick_dm ? dm_addr : if_addr;
                  if (pick_dm) mem_wdata <= dm_wdata;
                  if_gnt   <= ~pick_dm;
                  dm_gnt   <= pick_dm;
               end
            end
            ISSUE: cnt_q <= LAT_M1;
            WAIT:  cnt_q <= cnt_q - 4'd1;
            DONE: begin
               last_winner_q <= sel_q;
               if (sel_q == SEL_DATA) begin
                  if (!op_we_q) dm_rdata <= mem_rdata;
                  dm_rvalid <= 1'b1;
               end else begin
                  if_rdata  <= mem_rdata;
                  if_rvalid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: one instance at latency 1, one at latency 4, each with a
// latency-accurate memory model; grants and responses are scoreboarded.
module tb_mips_mem_arbiter;

   localparam int AW = 18;
   localparam int DW = 32;

   logic          clock = 1'b0;
   logic          reset_n   [2];
   logic          if_req    [2];
   logic [AW-1:0] if_addr   [2];
   logic          if_gnt    [2];
   logic          if_rvalid [2];
   logic [DW-1:0] if_rdata  [2];
   logic          dm_req    [2];
   logic          dm_we     [2];
   logic          dm_byte   [2];
   logic [AW-1:0] dm_addr   [2];
   logic [DW-1:0] dm_wdata  [2];
   logic          dm_gnt    [2];
   logic          dm_rvalid [2];
   logic [DW-1:0] dm_rdata  [2];
   logic          mem_en    [2];
   logic          mem_we    [2];
   logic          mem_byte  [2];
   logic [AW-1:0] mem_addr  [2];
   logic [DW-1:0] mem_wdata [2];
   logic [DW-1:0] mem_rdata [2];

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   mips_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1)) u_dut_l1 (
      .clock(clock), .reset_n(reset_n[0]),
      .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
      .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
      .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_byte(dm_byte[0]), .dm_addr(dm_addr[0]),
      .dm_wdata(dm_wdata[0]), .dm_gnt(dm_gnt[0]), .dm_rvalid(dm_rvalid[0]),
      .dm_rdata(dm_rdata[0]),
      .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_byte(mem_byte[0]),
      .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
   );

   mips_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(4)) u_dut_l4 (
      .clock(clock), .reset_n(reset_n[1]),
      .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
      .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
      .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_byte(dm_byte[1]), .dm_addr(dm_addr[1]),
      .dm_wdata(dm_wdata[1]), .dm_gnt(dm_gnt[1]), .dm_rvalid(dm_rvalid[1]),
      .dm_rdata(dm_rdata[1]),
      .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_byte(mem_byte[1]),
      .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
   );

   function automatic int lat_of(input int i);
      return (i == 0) ? 1 : 4;
   endfunction

   // ---------------- memory model ----------------
   // Read data is driven only in the cycle exactly LAT cycles after mem_en; garbage otherwise.
   for (genvar g = 0; g < 2; g++) begin : gen_mem
      localparam int L = (g == 0) ? 1 : 4;
      localparam bit HAS_JUMP = (g == 0);
      logic [DW-1:0] store [1024];
      logic [1023:0] written = '0;
      logic [15:0]   pipe    = '0;
      logic [DW-1:0] rd_word = '0;
      logic [DW-1:0] cur;
      logic [9:0]    a;

      function automatic logic [DW-1:0] peek(input logic [9:0] ad);
         if (written[ad]) return store[ad];
         if (HAS_JUMP && ad == 10'd4) return 32'h0801_0004;
         return 32'hA500_0000 | {22'd0, ad};
      endfunction

      always @(posedge clock) begin
         pipe <= {pipe[14:0], mem_en[g]};
         if (mem_en[g]) begin
            a = mem_addr[g][9:0];
            cur = peek(a);
            rd_word <= cur;
            if (mem_we[g]) begin
               store[a]   <= mem_byte[g] ? {cur[31:8], mem_wdata[g][7:0]} : mem_wdata[g];
               written[a] <= 1'b1;
            end
         end
      end

      assign mem_rdata[g] = pipe[L-1] ? rd_word : 32'hDEAD_BEEF;
   end

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic          inst;
      logic          port;
      logic          we;
      logic          byt;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } gexp_t;

   int            checks = 0;
   int            errors = 0;
   logic [33:0]   exp_q [$];
   gexp_t         gnt_q [$];
   logic          order_q [$];
   int            last_gnt_cyc [2] = '{0, 0};
   int            en_cnt [2] = '{0, 0};
   logic          prev_en [2] = '{1'b0, 1'b0};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   int          midx;
   logic        mp;
   gexp_t       me;
   logic [33:0] qe;

   // Monitor: protocol invariants every cycle, grants and responses against the queues.
   always @(negedge clock) begin
      for (int i = 0; i < 2; i++) begin
         check($sformatf("excl%0d", i),
               64'({if_gnt[i] & dm_gnt[i], if_rvalid[i] & dm_rvalid[i], mem_en[i] & prev_en[i],
                    mem_we[i] & ~mem_en[i], mem_en[i] ^ (if_gnt[i] | dm_gnt[i])}), 64'd0);
         prev_en[i] = mem_en[i];
         if (mem_en[i]) en_cnt[i]++;

         if (if_gnt[i] | dm_gnt[i]) begin
            mp = dm_gnt[i];
            last_gnt_cyc[i] = cyc;
            if (i == 0) order_q.push_back(mp);
            midx = -1;
            for (int k = 0; k < gnt_q.size(); k++)
               if (midx < 0 && gnt_q[k].inst == 1'(i) && gnt_q[k].port == mp) midx = k;
            if (midx < 0) begin
               checks++;
               errors++;
               $display("FAIL gnt_unexpected: inst %0d port %0d granted, expected no grant", i, mp);
            end else begin
               me = gnt_q[midx];
               gnt_q.delete(midx);
               check($sformatf("mem_we%0d", i), 64'(mem_we[i]), 64'(me.we));
               check($sformatf("mem_byte%0d", i), 64'(mem_byte[i]), 64'(me.byt));
               check($sformatf("mem_addr%0d", i), 64'(mem_addr[i]), 64'(me.addr));
               if (mp) check($sformatf("mem_wdata%0d", i), 64'(mem_wdata[i]), 64'(me.wdata));
            end
         end

         if (if_rvalid[i] | dm_rvalid[i]) begin
            mp = dm_rvalid[i];
            check($sformatf("rv_cycle%0d", i), 64'(cyc), 64'(last_gnt_cyc[i] + lat_of(i) + 1));
            midx = -1;
            for (int k = 0; k < exp_q.size(); k++) begin
               qe = exp_q[k];
               if (midx < 0 && qe[33:32] == {1'(i), mp}) midx = k;
            end
            if (midx < 0) begin
               checks++;
               errors++;
               $display("FAIL rv_unexpected: inst %0d port %0d rvalid, expected none", i, mp);
            end else begin
               qe = exp_q[midx];
               exp_q.delete(midx);
               if (mp) check($sformatf("dm_rdata%0d", i), 64'(dm_rdata[i]), 64'(qe[31:0]));
               else    check($sformatf("if_rdata%0d", i), 64'(if_rdata[i]), 64'(qe[31:0]));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_access(input int i, input logic p, input logic we, input logic byt,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic [DW-1:0] exp_data, input int exp_lat,
                            input bit expect_rv, input bit wait_rv);
      gexp_t ge;
      int    t0;
      logic  got;
      ge.inst = 1'(i); ge.port = p; ge.we = we; ge.byt = byt; ge.addr = addr; ge.wdata = wdata;
      gnt_q.push_back(ge);
      if (expect_rv) exp_q.push_back({1'(i), p, exp_data});
      if (p) begin
         dm_req[i] = 1'b1; dm_we[i] = we; dm_byte[i] = byt; dm_addr[i] = addr; dm_wdata[i] = wdata;
      end else begin
         if_req[i] = 1'b1; if_addr[i] = addr;
      end
      t0  = cyc;
      got = 1'b0;
      for (int n = 0; n < 100 && !got; n++) begin
         @(negedge clock);
         got = p ? dm_gnt[i] : if_gnt[i];
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL gnt_timeout: inst %0d port %0d got no grant, expected one", i, p);
      end else if (exp_lat >= 0) begin
         check($sformatf("gnt_lat%0d_%0d", i, p), 64'(cyc - t0), 64'(exp_lat));
      end
      @(posedge clock); #1;
      if (p) dm_req[i] = 1'b0; else if_req[i] = 1'b0;
      if (wait_rv && got) begin
         got = 1'b0;
         for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clock);
            got = p ? dm_rvalid[i] : if_rvalid[i];
         end
         if (!got) begin
            checks++;
            errors++;
            $display("FAIL rv_timeout: inst %0d port %0d got no rvalid, expected one", i, p);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic check_zero(input int i);
      check($sformatf("rst_if_gnt%0d", i), 64'(if_gnt[i]), 64'd0);
      check($sformatf("rst_if_rvalid%0d", i), 64'(if_rvalid[i]), 64'd0);
      check($sformatf("rst_if_rdata%0d", i), 64'(if_rdata[i]), 64'd0);
      check($sformatf("rst_dm_gnt%0d", i), 64'(dm_gnt[i]), 64'd0);
      check($sformatf("rst_dm_rvalid%0d", i), 64'(dm_rvalid[i]), 64'd0);
      check($sformatf("rst_dm_rdata%0d", i), 64'(dm_rdata[i]), 64'd0);
      check($sformatf("rst_mem_en%0d", i), 64'(mem_en[i]), 64'd0);
      check($sformatf("rst_mem_we%0d", i), 64'(mem_we[i]), 64'd0);
      check($sformatf("rst_mem_byte%0d", i), 64'(mem_byte[i]), 64'd0);
      check($sformatf("rst_mem_addr%0d", i), 64'(mem_addr[i]), 64'd0);
      check($sformatf("rst_mem_wdata%0d", i), 64'(mem_wdata[i]), 64'd0);
   endtask

   task automatic pulse_reset(input int i);
      reset_n[i] = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset_n[i] = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   logic [3:0] order_bits;

   initial begin
      for (int i = 0; i < 2; i++) begin
         reset_n[i] = 1'b0;
         if_req[i] = 1'b0; if_addr[i] = '0;
         dm_req[i] = 1'b0; dm_we[i] = 1'b0; dm_byte[i] = 1'b0; dm_addr[i] = '0; dm_wdata[i] = '0;
      end
      repeat (3) @(posedge clock);
      #1;
      check_zero(0);
      check_zero(1);
      reset_n[0] = 1'b1;
      reset_n[1] = 1'b1;
      @(posedge clock); #1;

      // Lone fetch at latency 1: gnt at cycle 1, rvalid at cycle 3.
      do_access(0, 1'b0, 1'b0, 1'b0, 18'h00004, '0, 32'h0801_0004, 1, 1'b1, 1'b1);

      // Tie straight after reset: data first, then alternation D,F,D,F.
      pulse_reset(0);
      order_q.delete();
      fork
         begin
            do_access(0, 1'b1, 1'b0, 1'b0, 18'h00010, '0, 32'hA500_0010, 1, 1'b1, 1'b1);
            do_access(0, 1'b1, 1'b0, 1'b0, 18'h00014, '0, 32'hA500_0014, 3, 1'b1, 1'b1);
         end
         begin
            do_access(0, 1'b0, 1'b0, 1'b0, 18'h00008, '0, 32'hA500_0008, 4, 1'b1, 1'b1);
            do_access(0, 1'b0, 1'b0, 1'b0, 18'h0000C, '0, 32'hA500_000C, 3, 1'b1, 1'b1);
         end
      join
      check("order_len", 64'(order_q.size()), 64'd4);
      order_bits = '0;
      for (int k = 0; k < 4 && k < order_q.size(); k++) order_bits[3-k] = order_q[k];
      check("order_dfdf", 64'(order_bits), 64'b1010);

      // Byte store: dm_rdata keeps the last load; read back shows the merged byte.
      do_access(0, 1'b1, 1'b1, 1'b1, 18'h00001, 32'h0000_00AB, 32'hA500_0014, 1, 1'b1, 1'b1);
      do_access(0, 1'b1, 1'b0, 1'b0, 18'h00001, '0, 32'hA500_00AB, 1, 1'b1, 1'b1);

      // Tie with data as last winner: fetch goes first.
      fork
         do_access(0, 1'b0, 1'b0, 1'b0, 18'h00020, '0, 32'hA500_0020, 1, 1'b1, 1'b1);
         do_access(0, 1'b1, 1'b0, 1'b0, 18'h00024, '0, 32'hA500_0024, 4, 1'b1, 1'b1);
      join

      // Latency 4 load: exactly one mem_en, rvalid five cycles after gnt.
      begin
         int en0;
         en0 = en_cnt[1];
         do_access(1, 1'b1, 1'b0, 1'b0, 18'h00100, '0, 32'hA500_0100, 1, 1'b1, 1'b1);
         check("l4_mem_en_count", 64'(en_cnt[1] - en0), 64'd1);
      end
      do_access(1, 1'b1, 1'b1, 1'b0, 18'h00200, 32'h1234_5678, 32'hA500_0100, 1, 1'b1, 1'b1);
      do_access(1, 1'b1, 1'b0, 1'b0, 18'h00200, '0, 32'h1234_5678, 1, 1'b1, 1'b1);

      // Reset in the middle of WAIT: everything clears, no response ever appears.
      do_access(1, 1'b1, 1'b0, 1'b0, 18'h00300, '0, '0, 1, 1'b0, 1'b0);
      #2;
      reset_n[1] = 1'b0;
      #1;
      check_zero(1);
      repeat (2) @(posedge clock);
      #1;
      check_zero(1);
      reset_n[1] = 1'b1;
      repeat (8) @(posedge clock);
      #1;
      do_access(1, 1'b0, 1'b0, 1'b0, 18'h00008, '0, 32'hA500_0008, 1, 1'b1, 1'b1);

      repeat (3) @(posedge clock);
      #1;
      check("exp_q_left", 64'(exp_q.size()), 64'd0);
      check("gnt_q_left", 64'(gnt_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Shares the single-port 18-bit-address data memory between two requesters: the instruction-fetch path (word reads at pc) and the load/store path (lw/sw/sb/lb, with a byte flag).
- Sequences each access through the memory's fixed read latency.
- Returns read data with a valid pulse, and grants alternately when both requesters contend.
- Sits between the processor datapath and memory_block; it enables the move from the current combinational single-cycle memory to a multi-cycle / shared-memory MIPS.

Parameters:
- ADDR_WIDTH, 18, memory address width (matches alu_result[17:0]).
- DATA_WIDTH, 32, data word width.
- MEM_LATENCY, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- if_req  input  1  fetch request; held until if_gnt.
- if_addr  input  ADDR_WIDTH  fetch address (pc).
- if_gnt  output  1  one-cycle pulse: fetch access issued.
- if_rvalid  output  1  one-cycle pulse: if_rdata valid.
- if_rdata  output  DATA_WIDTH  fetched instruction word.
- dm_req  input  1  data request; held until dm_gnt.
- dm_we  input  1  1 = store, 0 = load.
- dm_byte  input  1  byte operation (sb/lb) flag.
- dm_addr  input  ADDR_WIDTH  data address.
- dm_wdata  input  DATA_WIDTH  store data; byte store uses [7:0].
- dm_gnt  output  1  one-cycle pulse: data access issued.
- dm_rvalid  output  1  one-cycle pulse: load data valid, or store complete.
- dm_rdata  output  DATA_WIDTH  load data.
- mem_en  output  1  memory access strobe, one cycle per access.
- mem_we  output  1  memory write enable; only ever high together with mem_en.
- mem_byte  output  1  byte operation to memory.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_rdata  input  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after mem_en.

Behaviour:
- Reset is asynchronous on reset_n low. It forces:
  - the FSM to IDLE;
  - every output to 0, including the rdata registers, mem_addr and mem_wdata;
  - last_winner to FETCH;
  - the latency counter to 0.
- An access in flight is aborted: no rvalid is produced and no further mem_en is issued.
- Resumption happens on the first rising clock edge after reset_n goes high.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE:
  - Samples if_req and dm_req.
  - Exactly one request pending: that requester wins.
  - Both pending: the requester that did not win last time wins (round-robin). With last_winner = FETCH at reset, data wins the first tie.
  - The winner's address, we, byte flag and wdata are latched, and the FSM goes to ISSUE.
  - Fetch is always a word read: we = 0, byte = 0.
- ISSUE (exactly one cycle):
  - mem_en = 1; mem_we, mem_byte, mem_addr and mem_wdata come from the latched values.
  - The winner's gnt pulses.
  - The counter loads MEM_LATENCY-1. Next state is DONE if MEM_LATENCY == 1, else WAIT.
- WAIT:
  - mem_en = 0; the counter decrements each cycle.
  - When the counter equals 1, the next state is DONE.
- DONE (mem_rdata valid this cycle):
  - Read: the winner's rdata register loads mem_rdata.
  - Store: dm_rdata is unchanged.
  - The winner's rvalid is asserted the following cycle, for one cycle.
  - last_winner is updated and the FSM returns to IDLE.
- Timing:
  - Request sampled in IDLE at cycle T: gnt and mem_en at T+1, DONE at T+MEM_LATENCY+1, rvalid at T+MEM_LATENCY+2.
  - The IDLE at T+MEM_LATENCY+2 may accept the next request in that same cycle.
  - Minimum period per access is MEM_LATENCY+2 cycles.
- Requester rules:
  - req, addr and wdata must be stable from assertion until gnt.
  - req must be low by the next IDLE unless a new access is wanted; any req seen high in IDLE is a new access.
  - The bench treats req dropping before gnt as a protocol violation, and the request is then not serviced.
- Exclusivity:
  - mem_en is never high in two consecutive cycles.
  - if_gnt and dm_gnt are never high together; likewise if_rvalid and dm_rvalid.
- Pass-through: addresses and data go through unmodified. There is no alignment check; byte extraction and sign handling belong to memory.
- Outside ISSUE: mem_addr, mem_wdata and mem_byte hold their last values, and mem_we = 0.

Test Plan:
- Reset, then if_req alone with if_addr=0x00004, MEM_LATENCY=1, mem_rdata=0x08010004 at DONE:
  - if_gnt and mem_en at cycle 1;
  - if_rvalid at cycle 3 with if_rdata=0x08010004;
  - mem_we = 0 throughout.
- Reset, then if_req and dm_req both high at cycle 0:
  - data wins first; fetch is granted at the next IDLE;
  - with both held continuously (re-requested after each rvalid), grants alternate D,F,D,F over 4 accesses.
- dm_req with dm_we=1, dm_byte=1, dm_addr=0x00001, dm_wdata=0x000000AB:
  - one mem_en with mem_we=1, mem_byte=1, mem_addr=0x00001, mem_wdata=0xAB;
  - dm_rvalid pulses;
  - dm_rdata keeps its prior value.
- MEM_LATENCY=4, load at dm_addr=0x00100:
  - mem_en at cycle 1, WAIT for 3 cycles, DONE at cycle 5, dm_rvalid at cycle 6;
  - mem_en is high in exactly one cycle.
- reset_n pulled low during WAIT (MEM_LATENCY=4), then released:
  - all outputs go to 0 immediately, with no rvalid;
  - after release, a new if_req is granted one cycle after it is sampled in IDLE.
